// File: rtl/conv_pkg.sv
// Shared types and sizes for the convolution frame loader and its pixel bank.
package conv_pkg;
   localparam int PIX_W     = 8;
   localparam int FRAME_DIM = 8;
   localparam int FRAME_PIX = FRAME_DIM * FRAME_DIM;
   localparam int IDX_W     = 6;

   typedef logic signed [PIX_W-1:0] pix_t;
   typedef pix_t [0:FRAME_DIM-1][0:FRAME_DIM-1] frame_t;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } ld_state_t;
endpackage

// File: rtl/conv_frame_bank.sv
// 64-entry pixel register bank: one indexed write per cycle, whole frame readable in parallel.
module conv_frame_bank
   import conv_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_idx,
   input  pix_t             i_pix,
   output frame_t           o_frame
);

   frame_t r_frame;

   // Raster index k maps to row k/8, column k%8.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_frame <= '0;
      else if (i_we)
         r_frame[i_idx[5:3]][i_idx[2:0]] <= i_pix;
   end

   assign o_frame = r_frame;

endmodule

// File: rtl/conv_frame_loader.sv
// Assembles raster pixels into an 8x8 frame and hands it to the convolution processor.
// Build option CONV_LOADER_PINGPONG_EN: two banks so the next frame fills while one is processed.
//
// state | meaning
// FILL  | accepting pixels into the fill bank
// ISSUE | one-cycle start pulse to the processor
// WAIT  | processor busy; issued frame held until out_st
module conv_frame_loader
   import conv_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  pix_t        i_pix_in,
   input  logic        i_pix_valid,
   input  logic        i_pix_sof,
   output logic        o_pix_ready,
   output frame_t      o_din,
   output logic        o_in_st,
   input  logic        i_out_st,
   output logic        o_busy,
   output logic        o_frame_err,
   output logic [15:0] o_frame_cnt
);

   ld_state_t        r_state, w_next_state;
   logic [IDX_W-1:0] r_idx, w_wr_idx;
   logic             r_pix_ready, r_frame_err;
   logic [15:0]      r_frame_cnt;
   logic             w_acc, w_drop, w_restart, w_we, w_last, w_done;
   logic             w_ready_nxt, w_idx_clr;

   assign w_acc     = i_pix_valid & r_pix_ready;
   assign w_drop    = w_acc & ~i_pix_sof & (r_idx == '0);
   assign w_restart = w_acc &  i_pix_sof & (r_idx != '0);
   assign w_we      = w_acc & ~w_drop;
   assign w_wr_idx  = i_pix_sof ? '0 : r_idx;
   assign w_last    = w_we & (w_wr_idx == IDX_W'(FRAME_PIX - 1));
   assign w_done    = i_out_st & (r_state == WAIT);

`ifdef CONV_LOADER_PINGPONG_EN
   logic   r_pend, w_pend_nxt, r_fill_sel, r_iss_sel, w_swap;
   frame_t w_bank0, w_bank1;

   // A bank that completes while the processor is busy parks in r_pend until out_st.
   always_comb begin
      w_next_state = r_state;
      w_swap       = 1'b0;
      w_pend_nxt   = r_pend;
      case (r_state)
         FILL: begin
            if (w_last) begin
               w_next_state = ISSUE;
               w_swap       = 1'b1;
            end
         end
         ISSUE: w_next_state = WAIT;
         WAIT: begin
            if (i_out_st) begin
               w_pend_nxt = 1'b0;
               if (r_pend | w_last) begin
                  w_next_state = ISSUE;
                  w_swap       = 1'b1;
               end else begin
                  w_next_state = FILL;
               end
            end else if (w_last) begin
               w_pend_nxt = 1'b1;
            end
         end
         default: w_next_state = FILL;
      endcase
   end

   assign w_ready_nxt = ~w_pend_nxt;
   assign w_idx_clr   = 1'b0;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pend     <= 1'b0;
         r_fill_sel <= 1'b0;
         r_iss_sel  <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
         if (w_swap) begin
            r_iss_sel  <= r_fill_sel;
            r_fill_sel <= ~r_fill_sel;
         end
      end
   end

   conv_frame_bank u_bank0 (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (w_we & ~r_fill_sel),
      .i_idx   (w_wr_idx),
      .i_pix   (i_pix_in),
      .o_frame (w_bank0)
   );

   conv_frame_bank u_bank1 (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (w_we & r_fill_sel),
      .i_idx   (w_wr_idx),
      .i_pix   (i_pix_in),
      .o_frame (w_bank1)
   );

   assign o_din = r_iss_sel ? w_bank1 : w_bank0;
`else
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         FILL:    if (w_last) w_next_state = ISSUE;
         ISSUE:   w_next_state = WAIT;
         WAIT:    if (i_out_st) w_next_state = FILL;
         default: w_next_state = FILL;
      endcase
   end

   assign w_ready_nxt = (w_next_state == FILL);
   assign w_idx_clr   = w_done;

   conv_frame_bank u_bank (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (w_we),
      .i_idx   (w_wr_idx),
      .i_pix   (i_pix_in),
      .o_frame (o_din)
   );
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= FILL;
         r_idx       <= '0;
         r_pix_ready <= 1'b0;
         r_frame_err <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_pix_ready <= w_ready_nxt;
         r_frame_err <= w_drop | w_restart;
         if (w_done)
            r_frame_cnt <= r_frame_cnt + 16'd1;
         // Index wraps 63 -> 0 on its own when a frame completes.
         if (w_we)
            r_idx <= w_wr_idx + 1'b1;
         else if (w_idx_clr)
            r_idx <= '0;
      end
   end

   assign o_pix_ready = r_pix_ready;
   assign o_in_st     = (r_state == ISSUE);
   assign o_busy      = (r_state == WAIT);
   assign o_frame_err = r_frame_err;
   assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Self-checking bench for conv_frame_loader: framing vector table plus frame-level sequences.
module tb_conv_frame_loader;
   import conv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   pix_t        pix_in;
   logic        pix_valid, pix_sof, out_st;
   logic        pix_ready, in_st, busy, frame_err;
   frame_t      din;
   logic [15:0] frame_cnt;

   int n_pass = 0, n_total = 0;
   int n_inst = 0, n_err = 0;

`ifdef CONV_LOADER_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   typedef struct {
      logic valid;
      logic sof;
      int   pix;
      logic exp_err;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   conv_frame_loader dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_pix_in    (pix_in),
      .i_pix_valid (pix_valid),
      .i_pix_sof   (pix_sof),
      .o_pix_ready (pix_ready),
      .o_din       (din),
      .o_in_st     (in_st),
      .i_out_st    (out_st),
      .o_busy      (busy),
      .o_frame_err (frame_err),
      .o_frame_cnt (frame_cnt)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n_inst += int'(in_st);
      n_err  += int'(frame_err);
   endtask

   task automatic do_reset();
      reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; out_st = 1'b0; pix_in = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic push(input int p, input logic sof, input int gap);
      int   t;
      logic acc;
      for (int g = 0; g < gap; g++) begin
         pix_valid = 1'b0;
         tick();
      end
      pix_in = pix_t'(p); pix_sof = sof; pix_valid = 1'b1;
      t = 0; acc = 1'b0;
      while (!acc && t < 200) begin
         acc = pix_ready;
         tick();
         t++;
      end
      pix_valid = 1'b0; pix_sof = 1'b0;
      if (!acc) begin
         n_total++;
         $display("FAIL accept_timeout: pixel %0d not accepted within 200 cycles", p);
      end
   endtask

   task automatic send_pixels(input int base, input int k0, input int k1, input bit gaps);
      for (int k = k0; k <= k1; k++)
         push(base + k, (k == 0), gaps ? int'($urandom_range(0, 2)) : 0);
   endtask

   function automatic int din_mism(input int base, input bit zero);
      int   m = 0;
      pix_t e;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            e = zero ? pix_t'(0) : pix_t'(base + r * 8 + c);
            if (din[r][c] !== e) m++;
         end
      return m;
   endfunction

   task automatic issue_checks(input string tag, input int base);
      chk({tag, "_in_st"}, in_st, 1);
      chk({tag, "_din"}, din_mism(base, 1'b0), 0);
      chk({tag, "_ready_issue"}, pix_ready, PP);
      tick();
      chk({tag, "_in_st_once"}, in_st, 0);
      chk({tag, "_busy"}, busy, 1);
   endtask

   task automatic complete(input string tag, input int exp_cnt);
      out_st = 1'b1;
      tick();
      out_st = 1'b0;
      chk({tag, "_busy_done"}, busy, 0);
      chk({tag, "_ready_done"}, pix_ready, 1);
      chk({tag, "_cnt"}, frame_cnt, exp_cnt);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0,  5, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 10, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 11, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 99, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 20, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 21, 1'b0};
      vecs[6] = '{1'b0, 1'b1,  7, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 22, 1'b0};

      pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0; out_st = 1'b0;
      tick(); tick();
      chk("rst_ready", pix_ready, 0);
      chk("rst_in_st", in_st, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_cnt", frame_cnt, 0);
      chk("rst_din", din_mism(0, 1'b1), 0);
      reset = 1'b0;
      tick();
      chk("ready_after_rst", pix_ready, 1);

      // Framing rules, one cycle per record
      n_inst = 0;
      for (int i = 0; i < 8; i++) begin
         pix_valid = vecs[i].valid; pix_sof = vecs[i].sof; pix_in = pix_t'(vecs[i].pix);
         tick();
         chk($sformatf("vec%0d_err", i), frame_err, vecs[i].exp_err);
         chk($sformatf("vec%0d_ready", i), pix_ready, 1);
      end
      pix_valid = 1'b0; pix_sof = 1'b0;
      chk("vec_din00", $signed(din[0][0]), 20);
      chk("vec_din01", $signed(din[0][1]), 21);
      chk("vec_din02", $signed(din[0][2]), 22);
      chk("vec_no_in_st", n_inst, 0);

      out_st = 1'b1;
      tick();
      out_st = 1'b0;
      chk("stray_out_st_cnt", frame_cnt, 0);
      chk("stray_out_st_err", frame_err, 0);
      chk("stray_out_st_in_st", in_st, 0);

      // Frame 0..63 without gaps
      do_reset();
      n_inst = 0;
      send_pixels(0, 0, 62, 1'b0);
      chk("t1_no_early_in_st", n_inst, 0);
      push(63, 1'b0, 0);
      chk("t1_din77", $signed(din[7][7]), 63);
      chk("t1_din00", $signed(din[0][0]), 0);
      issue_checks("t1", 0);
`ifdef CONV_LOADER_PINGPONG_EN
      complete("t1", 1);
`else
      pix_in = 8'sd77; pix_sof = 1'b1; pix_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_ready_wait", pix_ready, 0);
         chk("t4_busy_wait", busy, 1);
      end
      chk("t4_din_hold", din_mism(0, 1'b0), 0);
      out_st = 1'b1;
      tick();
      out_st = 1'b0;
      chk("t4_ready_resume", pix_ready, 1);
      chk("t4_busy_done", busy, 0);
      chk("t4_cnt", frame_cnt, 1);
      chk("t4_din_after_out_st", din_mism(0, 1'b0), 0);
      tick();
      pix_valid = 1'b0; pix_sof = 1'b0;
      chk("t4_first_pixel", $signed(din[0][0]), 77);
`endif

      // Negative frame with random valid gaps
      n_inst = 0;
      send_pixels(-128, 0, 62, 1'b1);
      chk("t2_no_early_in_st", n_inst, 0);
      push(-65, 1'b0, 1);
      chk("t2_din35", $signed(din[3][5]), -99);
      issue_checks("t2", -128);
      complete("t2", 2);

      // Restart by sof at k=20
      do_reset();
      n_err = 0; n_inst = 0;
      send_pixels(100, 0, 19, 1'b0);
      send_pixels(-20, 0, 62, 1'b0);
      chk("t3_no_early_in_st", n_inst, 0);
      push(43, 1'b0, 0);
      issue_checks("t3", -20);
      chk("t3_err_pulses", n_err, 1);
      complete("t3", 1);

      // Reset at k=40
      send_pixels(7, 0, 39, 1'b0);
      reset = 1'b1;
      #1;
      chk("t5_ready", pix_ready, 0);
      chk("t5_in_st", in_st, 0);
      chk("t5_busy", busy, 0);
      chk("t5_err", frame_err, 0);
      chk("t5_cnt", frame_cnt, 0);
      chk("t5_din", din_mism(0, 1'b1), 0);
      reset = 1'b0;
      tick();
      chk("t5_ready_after", pix_ready, 1);
      send_pixels(3, 0, 62, 1'b0);
      push(66, 1'b0, 0);
      issue_checks("t5", 3);
      complete("t5", 1);

`ifdef CONV_LOADER_PINGPONG_EN
      // Frame B fully loaded before frame A completes
      do_reset();
      send_pixels(0, 0, 63, 1'b0);
      issue_checks("pp_a", 0);
      send_pixels(-64, 0, 63, 1'b0);
      chk("pp_ready_pend", pix_ready, 0);
      chk("pp_busy_pend", busy, 1);
      chk("pp_din_a_held", din_mism(0, 1'b0), 0);
      tick(); tick();
      out_st = 1'b1;
      tick();
      out_st = 1'b0;
      chk("pp_in_st_b", in_st, 1);
      chk("pp_din_b", din_mism(-64, 1'b0), 0);
      chk("pp_cnt_a", frame_cnt, 1);
      chk("pp_ready_b", pix_ready, 1);
      tick();
      chk("pp_busy_b", busy, 1);
      complete("pp_b", 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
